// File: rtl/midi_pkg.sv
// Shared MIDI definitions: channel-voice status nibbles, sender FSM states,
// and the data-byte count for each status.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CTRL     = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHAN_AT  = 4'hD;
  localparam logic [3:0] BEND     = 4'hE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_STATUS,
    ST_SEND_D0,
    ST_SEND_D1,
    ST_ERROR
  } tx_state_e;

  // Zero marks a status this sender does not transmit.
  function automatic logic [1:0] data_byte_count(input logic [3:0] status);
    case (status)
      NOTE_OFF, NOTE_ON, POLY_AT, CTRL, BEND: data_byte_count = 2'd2;
      PROG, CHAN_AT:                          data_byte_count = 2'd1;
      default:                                data_byte_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/midi_byte_writer.sv
// UART framer for MIDI OUT: start bit, 8 data bits LSB first, stop bit.
// Accepts the next byte during the last stop-bit clock so frames run back-to-back.
module midi_byte_writer #(
  parameter int CLKS_PER_BIT = 800
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_i,
  output logic       byte_ready_o,
  output logic       done_o,
  output logic       busy_o,
  output logic       tx_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  logic          active_q, active_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [9:0]    shift_q, shift_d;
  logic          last_clk;

  assign last_clk     = active_q && (bit_idx_q == 4'd9) && (baud_cnt_q == BAUD_LAST);
  assign byte_ready_o = !active_q || last_clk;
  assign done_o       = last_clk;
  assign busy_o       = active_q;
  // Driven from reset-cleared state, so the line returns high as soon as reset asserts.
  assign tx_o         = active_q ? shift_q[0] : 1'b1;

  always_comb begin
    active_d   = active_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    if (byte_valid_i && byte_ready_o) begin
      active_d   = 1'b1;
      baud_cnt_d = '0;
      bit_idx_d  = 4'd0;
      shift_d    = {1'b1, byte_i, 1'b0};
    end else if (last_clk) begin
      active_d   = 1'b0;
      baud_cnt_d = '0;
      bit_idx_d  = 4'd0;
    end else if (active_q) begin
      if (baud_cnt_q == BAUD_LAST) begin
        baud_cnt_d = '0;
        bit_idx_d  = bit_idx_q + 4'd1;
        shift_d    = {1'b1, shift_q[9:1]};
      end else begin
        baud_cnt_d = baud_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      baud_cnt_q <= '0;
      bit_idx_q  <= 4'd0;
      shift_q    <= '1;
    end else begin
      active_q   <= active_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
    end
  end

endmodule

// File: rtl/midi_message_sender.sv
// MIDI channel-voice message sender: latches a request, optionally drops a
// repeated status byte (running status) and feeds bytes to the framer.
module midi_message_sender
  import midi_pkg::*;
#(
  parameter int CLK_HZ         = 25000000,
  parameter int BAUD           = 31250,
  parameter int RUNNING_STATUS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       msg_valid,
  output logic       msg_ready,
  input  logic [3:0] msg_status,
  input  logic [3:0] msg_channel,
  input  logic [6:0] msg_data0,
  input  logic [6:0] msg_data1,
  output logic       msg_error,
  output logic       busy,
  output logic       MIDI_TX
);

  localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;

  tx_state_e  state_q, state_d;
  logic [7:0] last_status_q, last_status_d;
  logic [7:0] d0_q, d0_d;
  logic [7:0] d1_q, d1_d;
  logic       three_q, three_d;

  logic       wr_valid, wr_ready, wr_done;
  logic [7:0] wr_byte;
  logic [7:0] new_status;
  logic [1:0] n_data;

  assign new_status = {msg_status, msg_channel};
  assign n_data     = data_byte_count(msg_status);

  midi_byte_writer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_writer (
    .clk         (clk),
    .rst_n       (rst_n),
    .byte_valid_i(wr_valid),
    .byte_i      (wr_byte),
    .byte_ready_o(wr_ready),
    .done_o      (wr_done),
    .busy_o      (busy),
    .tx_o        (MIDI_TX)
  );

  always_comb begin
    state_d       = state_q;
    last_status_d = last_status_q;
    d0_d          = d0_q;
    d1_d          = d1_q;
    three_d       = three_q;
    wr_valid      = 1'b0;
    wr_byte       = 8'h00;
    msg_ready     = 1'b0;
    msg_error     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        msg_ready = wr_ready;
        if (msg_valid && wr_ready) begin
          d0_d    = {1'b0, msg_data0};
          d1_d    = {1'b0, msg_data1};
          three_d = (n_data == 2'd2);
          // The first byte goes to the framer in the acceptance cycle itself,
          // which is what gives the one-cycle start-bit latency.
          if (n_data == 2'd0) begin
            state_d = ST_ERROR;
          end else if ((RUNNING_STATUS != 0) && (new_status == last_status_q)) begin
            wr_valid = 1'b1;
            wr_byte  = {1'b0, msg_data0};
            state_d  = ST_SEND_D0;
          end else begin
            wr_valid      = 1'b1;
            wr_byte       = new_status;
            last_status_d = new_status;
            state_d       = ST_SEND_STATUS;
          end
        end
      end
      ST_SEND_STATUS: begin
        if (wr_done) begin
          wr_valid = 1'b1;
          wr_byte  = d0_q;
          state_d  = ST_SEND_D0;
        end
      end
      ST_SEND_D0: begin
        if (wr_done) begin
          if (three_q) begin
            wr_valid = 1'b1;
            wr_byte  = d1_q;
            state_d  = ST_SEND_D1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_SEND_D1: begin
        if (wr_done) state_d = ST_IDLE;
      end
      ST_ERROR: begin
        msg_error = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      last_status_q <= 8'h00;
      d0_q          <= 8'h00;
      d1_q          <= 8'h00;
      three_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_status_q <= last_status_d;
      d0_q          <= d0_d;
      d1_q          <= d1_d;
      three_q       <= three_d;
    end
  end

endmodule

// File: tb/tb_midi_message_sender.sv
// Bench for midi_message_sender: three instances (running status on/off at a
// fast bit rate, and the default 800-clock bit) checked against a byte-level model.
module tb_midi_message_sender;

  localparam int BAUD     = 31250;
  localparam int FAST_HZ  = 265625;
  localparam int CPB_FAST = (FAST_HZ + BAUD / 2) / BAUD;
  localparam int CPB_SLOW = (25000000 + BAUD / 2) / BAUD;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] valid_v = 3'b000;
  logic [3:0] st_i = 4'h0, ch_i = 4'h0;
  logic [6:0] d0_i = 7'h00, d1_i = 7'h00;
  logic [2:0] ready_v, err_v, busy_v, tx_v;
  logic [1:0] sel = 2'd0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] last_model [3];
  int cpb_of [3] = '{CPB_FAST, CPB_FAST, CPB_SLOW};
  bit rs_of  [3] = '{1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  midi_message_sender #(.CLK_HZ(FAST_HZ), .BAUD(BAUD), .RUNNING_STATUS(1)) dut_rs (
    .clk(clk), .rst_n(rst_n), .msg_valid(valid_v[0]), .msg_ready(ready_v[0]),
    .msg_status(st_i), .msg_channel(ch_i), .msg_data0(d0_i), .msg_data1(d1_i),
    .msg_error(err_v[0]), .busy(busy_v[0]), .MIDI_TX(tx_v[0]));

  midi_message_sender #(.CLK_HZ(FAST_HZ), .BAUD(BAUD), .RUNNING_STATUS(0)) dut_nors (
    .clk(clk), .rst_n(rst_n), .msg_valid(valid_v[1]), .msg_ready(ready_v[1]),
    .msg_status(st_i), .msg_channel(ch_i), .msg_data0(d0_i), .msg_data1(d1_i),
    .msg_error(err_v[1]), .busy(busy_v[1]), .MIDI_TX(tx_v[1]));

  midi_message_sender dut_slow (
    .clk(clk), .rst_n(rst_n), .msg_valid(valid_v[2]), .msg_ready(ready_v[2]),
    .msg_status(st_i), .msg_channel(ch_i), .msg_data0(d0_i), .msg_data1(d1_i),
    .msg_error(err_v[2]), .busy(busy_v[2]), .MIDI_TX(tx_v[2]));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d got=%0h expected=%0h", tag, sel, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_tx"},    32'(tx_v[sel]),   32'd1);
    check_val({tag, "_busy"},  32'(busy_v[sel]), 32'd0);
    check_val({tag, "_error"}, 32'(err_v[sel]),  32'd0);
  endtask

  // Issue one request on instance sel and check every line clock it produces.
  // Called at a quiet point (after a negedge or just after a posedge).
  task automatic send_msg(input logic [3:0] st, input logic [3:0] ch,
                          input logic [6:0] d0, input logic [6:0] d1, input bit hold);
    logic [7:0] exp_q [$];
    logic [7:0] sb;
    logic [9:0] obs;
    int nd, waited, cpb, unstable, bad_busy, bad_ctrl;
    cpb = cpb_of[sel];
    sb  = {st, ch};
    if ((st >= 4'h8 && st <= 4'hB) || st == 4'hE) nd = 2;
    else if (st == 4'hC || st == 4'hD)            nd = 1;
    else                                          nd = 0;
    if (nd > 0) begin
      if (!(rs_of[sel] && sb == last_model[sel])) begin
        exp_q.push_back(sb);
        last_model[sel] = sb;
      end
      exp_q.push_back({1'b0, d0});
      if (nd == 2) exp_q.push_back({1'b0, d1});
    end

    st_i = st; ch_i = ch; d0_i = d0; d1_i = d1;
    valid_v = 3'b000;
    valid_v[sel] = 1'b1;
    waited = 0;
    while (!ready_v[sel] && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check_val("ready_before_accept", 32'(ready_v[sel]), 32'd1);
    @(posedge clk);
    #1;
    st_i = 4'($urandom); ch_i = 4'($urandom);
    d0_i = 7'($urandom); d1_i = 7'($urandom);
    if (!hold) valid_v = 3'b000;
    $display("[TB] inst%0d status=%h ch=%0d d0=%h d1=%h expect %0d bytes",
             sel, st, ch, d0, d1, exp_q.size());

    if (nd == 0) begin
      @(negedge clk);
      check_val("error_pulse",     32'(err_v[sel]),   32'd1);
      check_val("ready_in_error",  32'(ready_v[sel]), 32'd0);
      check_val("tx_in_error",     32'(tx_v[sel]),    32'd1);
      @(negedge clk);
      check_val("error_cleared",   32'(err_v[sel]),   32'd0);
      check_val("ready_after_err", 32'(ready_v[sel]), 32'd1);
      check_val("tx_after_err",    32'(tx_v[sel]),    32'd1);
    end else begin
      foreach (exp_q[k]) begin
        obs = '0; unstable = 0; bad_busy = 0; bad_ctrl = 0;
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c < cpb; c++) begin
            @(negedge clk);
            if (c == 0) obs[b] = tx_v[sel];
            else if (tx_v[sel] !== obs[b]) unstable++;
            if (busy_v[sel] !== 1'b1) bad_busy++;
            if (ready_v[sel] !== 1'b0 || err_v[sel] !== 1'b0) bad_ctrl++;
          end
        end
        check_val("frame",          32'(obs), 32'({1'b1, exp_q[k], 1'b0}));
        check_val("bit_width",      32'(unstable), 32'd0);
        check_val("busy_in_frame",  32'(bad_busy), 32'd0);
        check_val("ctrl_in_frame",  32'(bad_ctrl), 32'd0);
      end
      @(negedge clk);
      check_val("ready_after_msg", 32'(ready_v[sel]), 32'd1);
      check_idle_outputs("after_msg");
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog inst=%0d simulation time limit reached", sel);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rst_st;
    bit hold;
    for (int i = 0; i < 3; i++) last_model[i] = 8'h00;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = 2'(i);
      check_idle_outputs("in_reset");
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = 2'(i);
      check_val("ready_after_reset", 32'(ready_v[sel]), 32'd1);
      check_idle_outputs("after_reset");
    end

    // Default rate: 800 clocks per bit, 24000 clocks for the message.
    sel = 2'd2;
    send_msg(4'h9, 4'h0, 7'h3C, 7'h64, 1'b0);

    sel = 2'd0;
    send_msg(4'h9, 4'h0, 7'h3C, 7'h64, 1'b0);
    send_msg(4'h9, 4'h0, 7'h40, 7'h50, 1'b0);
    sel = 2'd1;
    send_msg(4'h9, 4'h0, 7'h3C, 7'h64, 1'b0);
    send_msg(4'h9, 4'h0, 7'h40, 7'h50, 1'b0);

    sel = 2'd0;
    send_msg(4'hC, 4'h3, 7'h05, 7'h33, 1'b0);
    send_msg(4'hB, 4'h3, 7'h01, 7'h7F, 1'b0);
    send_msg(4'h9, 4'h0, 7'h01, 7'h02, 1'b0);
    send_msg(4'hF, 4'h0, 7'h11, 7'h22, 1'b0);
    send_msg(4'h9, 4'h0, 7'h03, 7'h00, 1'b0);

    // Reset in data bit 4 of a Note Off status byte (0x80, that bit is 0).
    rst_st = 4'h8;
    st_i = rst_st; ch_i = 4'h0; d0_i = 7'h11; d1_i = 7'h22;
    valid_v = 3'b001;
    check_val("ready_before_reset_msg", 32'(ready_v[0]), 32'd1);
    @(posedge clk);
    #1 valid_v = 3'b000;
    $display("[TB] inst0 status=%h ch=0 reset asserted in data bit 4", rst_st);
    repeat (5 * CPB_FAST + CPB_FAST / 2 + 1) @(negedge clk);
    check_val("tx_bit4_before_reset", 32'(tx_v[0]), 32'd0);
    check_val("busy_before_reset",    32'(busy_v[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_frame_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) last_model[i] = 8'h00;
    @(negedge clk);
    send_msg(4'h9, 4'h0, 7'h3C, 7'h64, 1'b0);

    // Held request: two pitch bends with one idle cycle between them.
    send_msg(4'hE, 4'hF, 7'h00, 7'h40, 1'b1);
    send_msg(4'hE, 4'hF, 7'h00, 7'h40, 1'b0);

    for (int s = 0; s < 2; s++) begin
      sel = 2'(s);
      for (int i = 0; i < 25; i++) begin
        logic [3:0] st;
        st = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) != 0) st = 4'($urandom_range(8, 14));
        hold = (i != 24) && ($urandom_range(0, 1) == 1);
        send_msg(st, 4'($urandom_range(0, 2)), 7'($urandom), 7'($urandom), hold);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/midi_message_sender.md
# midi_message_sender

Serializes MIDI channel-voice messages (Note On/Off, Controller Change, Program Change, Pitch Bend, pressure) into a 31250-baud MIDI_TX serial stream, with optional running-status compression. It is the transmit-side counterpart of the MIDI input path. It sits between synth control logic (sequencer, arpeggiator, MIDI-thru) and the MIDI OUT pin.

## Interface
- CLK_HZ, 25000000, system clock frequency in Hz
- BAUD, 31250, serial bit rate
- RUNNING_STATUS, 1, when 1, omit the status byte if it equals the last status byte sent

- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- msg_valid  input  1  message request
- msg_ready  output  1  block can accept a message this cycle
- msg_status  input  4  status nibble (8..E)
- msg_channel  input  4  MIDI channel 0..15
- msg_data0  input  7  first data byte (note, controller, program, bend LSB)
- msg_data1  input  7  second data byte (velocity, value, bend MSB); ignored for 2-byte messages
- msg_error  output  1  one-cycle pulse when an unsupported status is accepted
- busy  output  1  high while any frame is on the line
- MIDI_TX  output  1  serial output, idle high

## Operation
- Accept on the rising clk edge where msg_valid && msg_ready. Latch all msg_* fields at acceptance; later input changes are ignored.
- Message length by status nibble:
  - 8, 9, A, B, E: status + 2 data bytes.
  - C, D: status + 1 data byte.
  - 0..7 and F: the request is accepted and dropped. msg_error pulses on the next cycle, nothing is transmitted, and running status is unchanged.
- Status byte = {msg_status, msg_channel}. Data bytes = {1'b0, msg_dataN}, so bit 7 is always 0.
- Running status:
  - last_status register, cleared to 0 on reset.
  - If RUNNING_STATUS=1 and the new status byte equals last_status, the status byte is skipped.
  - Otherwise the status byte is sent and last_status is updated.
  - A Note On with velocity 0 is sent as-is. No conversion between Note On and Note Off.
- FSM states:
  - IDLE: msg_ready=1.
  - SEND_STATUS, then SEND_D0, then SEND_D1 (SEND_D1 skipped for 2-byte messages), then back to IDLE.
  - From IDLE, acceptance goes to SEND_STATUS, or directly to SEND_D0 when running status applies.
  - Each SEND_* state hands one byte to the framer and advances when the framer reports frame done.
- Framer: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.

## Timing
- CLKS_PER_BIT = (CLK_HZ + BAUD/2) / BAUD, which is 800 at the defaults. A frame is 10*CLKS_PER_BIT clocks.
- The MIDI_TX start bit begins on the clock after acceptance (1-cycle latency).
- Consecutive bytes of one message are back-to-back: the next start bit begins on the cycle after the stop bit's last clock. No idle gap.
- msg_ready:
  - Deasserts the cycle after acceptance.
  - Reasserts the cycle after the final stop bit completes.
  - For an error drop, reasserts the cycle after the msg_error pulse.
- busy is high from the first start-bit clock through the last stop-bit clock.
- Reset values: MIDI_TX=1, msg_ready=1 (once rst_n is high), msg_error=0, busy=0, state IDLE, last_status=0, bit counters 0.
- Reset asserted mid-frame: MIDI_TX goes high asynchronously and the partial byte is abandoned. Because last_status is cleared, the next message always sends its status byte.
- msg_valid held high continuously: messages are sent back-to-back, with one idle cycle (the IDLE acceptance cycle) between messages.

## Structure
- Shared package midi_pkg holds:
  - status nibble constants (NOTE_OFF=8, NOTE_ON=9, POLY_AT=A, CTRL=B, PROG=C, CHAN_AT=D, BEND=E)
  - a function returning the data-byte count per status
- Sub-module midi_byte_writer: UART framer with a byte_valid/byte_ready handshake, the CLKS_PER_BIT baud counter, a 4-bit bit index, a shift register and a done pulse. It is the counterpart of the existing byte reader.
- Top-level midi_message_sender holds the FSM, message latch and running-status logic.

## Test plan
- Note On, ch 0, note 0x3C, velocity 0x64 from reset -> MIDI_TX frames 0x90, 0x3C, 0x64. Bit width is exactly 800 clocks, 24000 clocks total. msg_ready returns the cycle after.
- Repeat Note On, ch 0, note 0x40, velocity 0x50 -> only 0x40, 0x50 sent (running status). With RUNNING_STATUS=0 -> 0x90, 0x40, 0x50.
- Program Change, ch 3, program 0x05, followed by Controller Change, ch 3, controller 1, value 0x7F -> 0xC3, 0x05, then 0xB3, 0x01, 0x7F.
- msg_status=F -> msg_error pulses for 1 cycle, MIDI_TX stays high, and a following Note On ch 0 still uses the running status set by earlier traffic.
- Assert rst_n low at bit 4 of a status byte -> MIDI_TX is 1 immediately. After release, Note On ch 0 transmits 0x90 again.
- Pitch Bend, ch 15, data0=0x00, data1=0x40 with msg_valid held high across two requests -> 0xEF, 0x00, 0x40, 0x00, 0x40. One idle cycle between the messages. No input corruption from inputs changing after acceptance.
